// File: rtl/washer_pkg.sv
// washer_pkg: state encoding shared by the washer controller and its bench.
package washer_pkg;
    localparam int STATE_W = 4;
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 4'd0,
        FILL      = 4'd1,
        DETERGENT = 4'd2,
        AGITATE   = 4'd3,
        DRAIN     = 4'd4,
        SPIN      = 4'd5,
        PAUSED    = 4'd6,
        DONE      = 4'd7,
        FAULT     = 4'd8
    } state_t;
endpackage

// File: rtl/washer_timer.sv
// washer_timer: loadable saturating down-counter; expired while the count is zero.
module washer_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               enable,
    output logic               expired
);
    logic [TIMER_W-1:0] count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && count != '0)
            count <= count - 1'b1;
    end
    assign expired = count == '0;
endmodule

// File: rtl/washer_ctrl_gen2.sv
// washer_ctrl_gen2: washing-machine sequencer with internal phase timer, fill/drain
// watchdogs, pause/resume, programmable rinses and a latched door/watchdog fault.
module washer_ctrl_gen2
    import washer_pkg::*;
#(
    parameter int TIMER_W       = 16,
    parameter int WASH_TICKS    = 1000,
    parameter int RINSE_TICKS   = 500,
    parameter int SPIN_TICKS    = 800,
    parameter int FILL_TIMEOUT  = 2000,
    parameter int DRAIN_TIMEOUT = 2000,
    parameter int MAX_RINSES    = 3,
    parameter int RINSE_W       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               door_closed,
    input  logic               filled,
    input  logic               drained,
    input  logic               detergent_added,
    input  logic [RINSE_W-1:0] rinse_count,
    output logic               door_lock,
    output logic               motor_on,
    output logic               motor_fast,
    output logic               fill_valve_on,
    output logic               drain_valve_on,
    output logic               done,
    output logic               fault,
    output logic [STATE_W-1:0] state_out,
    output logic [RINSE_W-1:0] rinses_left
);
    localparam logic [RINSE_W-1:0] MAX_R = RINSE_W'(MAX_RINSES);
    state_t state, next_state, ret_state;
    logic wash_phase, phase_expired, dog_expired, phase_load, dog_load;
    logic [TIMER_W-1:0] phase_value, dog_value;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = (start && door_closed) ? FILL : IDLE;
            FILL:      next_state = filled ? (wash_phase ? DETERGENT : AGITATE) : (dog_expired ? FAULT : FILL);
            DETERGENT: next_state = detergent_added ? AGITATE : DETERGENT;
            AGITATE:   next_state = phase_expired ? DRAIN : (pause ? PAUSED : AGITATE);
            DRAIN:     next_state = drained ? ((rinses_left != '0) ? FILL : SPIN) : (dog_expired ? FAULT : DRAIN);
            SPIN:      next_state = phase_expired ? DONE : (pause ? PAUSED : SPIN);
            PAUSED:    next_state = pause ? PAUSED : ret_state;
            DONE:      next_state = start ? DONE : IDLE;
            default:   next_state = FAULT;
        endcase
        if (!door_closed && !(state inside {IDLE, DONE, FAULT}))
            next_state = FAULT;
    end
    // Timers load N-1 on phase entry so a phase lasts exactly N cycles; resuming from PAUSED keeps the count.
    assign phase_load  = (next_state inside {AGITATE, SPIN}) && next_state != state && state != PAUSED;
    assign phase_value = (next_state == SPIN) ? TIMER_W'(SPIN_TICKS - 1) :
                         wash_phase ? TIMER_W'(WASH_TICKS - 1) : TIMER_W'(RINSE_TICKS - 1);
    assign dog_load    = (next_state inside {FILL, DRAIN}) && next_state != state;
    assign dog_value   = (next_state == FILL) ? TIMER_W'(FILL_TIMEOUT - 1) : TIMER_W'(DRAIN_TIMEOUT - 1);
    washer_timer #(.TIMER_W(TIMER_W)) u_phase (
        .clk(clk), .reset(reset), .load(phase_load), .load_value(phase_value),
        .enable(state inside {AGITATE, SPIN}), .expired(phase_expired)
    );
    washer_timer #(.TIMER_W(TIMER_W)) u_dog (
        .clk(clk), .reset(reset), .load(dog_load), .load_value(dog_value),
        .enable(state inside {FILL, DRAIN}), .expired(dog_expired)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ret_state      <= IDLE;
            rinses_left    <= '0;
            wash_phase     <= 1'b1;
            door_lock      <= 1'b0;
            motor_on       <= 1'b0;
            motor_fast     <= 1'b0;
            fill_valve_on  <= 1'b0;
            drain_valve_on <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == FILL) begin
                rinses_left <= (rinse_count > MAX_R) ? MAX_R : rinse_count;
                wash_phase  <= 1'b1;
            end else if (state == DRAIN && next_state == FILL) begin
                rinses_left <= rinses_left - 1'b1;
                wash_phase  <= 1'b0;
            end
            if (next_state == PAUSED && state != PAUSED)
                ret_state <= state;
            // Outputs decode the next state so they switch on the same edge as the state.
            door_lock      <= (next_state inside {FILL, DETERGENT, AGITATE, DRAIN, SPIN, PAUSED}) ||
                              (next_state == FAULT && !drained);
            motor_on       <= next_state inside {AGITATE, SPIN};
            motor_fast     <= next_state == SPIN;
            fill_valve_on  <= next_state == FILL;
            drain_valve_on <= (next_state inside {DRAIN, SPIN}) || (next_state == FAULT && !drained);
            done           <= next_state == DONE;
            fault          <= next_state == FAULT;
        end
    end
    assign state_out = state;
endmodule

// File: tb/tb_washer_ctrl_gen2.sv
// tb_washer_ctrl_gen2: directed checks of the washer sequencer; a second instance
// with MAX_RINSES=1 and always-ready sensors covers the rinse clamp.
module tb_washer_ctrl_gen2;
    import washer_pkg::*;
    logic clk = 1'b0, reset = 1'b1;
    logic start = 0, pause = 0, door_closed = 1, filled = 1, drained = 1, detergent_added = 1;
    logic [1:0] rinse_count = 2'd1;
    logic door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on, done, fault;
    logic [3:0] st;
    logic [1:0] rl;
    logic start2 = 0;
    logic door_lock2, motor_on2, motor_fast2, fill2, drain2, done2, fault2;
    logic [3:0] st2;
    logic [1:0] rl2;
    logic [6:0] outs, outs2;
    logic [63:0] seq;
    logic [31:0] rl_seq, rl_seq2;
    int agi_cycles, agi_runs, fast_cycles, agi_runs2, n;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    washer_ctrl_gen2 #(.WASH_TICKS(4), .RINSE_TICKS(2), .SPIN_TICKS(3), .FILL_TIMEOUT(8),
                       .DRAIN_TIMEOUT(8), .MAX_RINSES(3), .RINSE_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .door_closed(door_closed),
        .filled(filled), .drained(drained), .detergent_added(detergent_added),
        .rinse_count(rinse_count), .door_lock(door_lock), .motor_on(motor_on),
        .motor_fast(motor_fast), .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .done(done), .fault(fault), .state_out(st), .rinses_left(rl)
    );

    washer_ctrl_gen2 #(.WASH_TICKS(4), .RINSE_TICKS(2), .SPIN_TICKS(3), .FILL_TIMEOUT(8),
                       .DRAIN_TIMEOUT(8), .MAX_RINSES(1), .RINSE_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .pause(1'b0), .door_closed(door_closed),
        .filled(1'b1), .drained(1'b1), .detergent_added(1'b1),
        .rinse_count(2'd2), .door_lock(door_lock2), .motor_on(motor_on2),
        .motor_fast(motor_fast2), .fill_valve_on(fill2), .drain_valve_on(drain2),
        .done(done2), .fault(fault2), .state_out(st2), .rinses_left(rl2)
    );

    assign outs  = {door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on, done, fault};
    assign outs2 = {door_lock2, motor_on2, motor_fast2, fill2, drain2, done2, fault2};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Follows a program until dut reaches DONE/FAULT, logging state changes and phase lengths.
    task automatic run_prog(input int budget);
        logic [3:0] prev, prev2;
        logic [1:0] prl, prl2;
        seq = '0; rl_seq = '0; rl_seq2 = '0;
        agi_cycles = 0; agi_runs = 0; fast_cycles = 0; agi_runs2 = 0;
        prev = st; prev2 = st2; prl = rl; prl2 = rl2;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (st != prev) begin
                seq = {seq[59:0], st};
                if (st == AGITATE) agi_runs++;
            end
            if (st2 != prev2 && st2 == AGITATE) agi_runs2++;
            if (st == AGITATE && motor_on) agi_cycles++;
            if (st == SPIN && motor_on && motor_fast) fast_cycles++;
            if (rl != prl) rl_seq = {rl_seq[27:0], 2'b00, rl};
            if (rl2 != prl2) rl_seq2 = {rl_seq2[27:0], 2'b00, rl2};
            prev = st; prev2 = st2; prl = rl; prl2 = rl2;
            if (st == DONE || st == FAULT) break;
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        for (int i = 0; i < budget && st != s; i++) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 64'(st), 64'(IDLE));
        check("reset_outs", 64'(outs), 0);
        check("reset_rinses", 64'(rl), 0);
        reset = 0;
        @(negedge clk);

        // Full run, one rinse
        start = 1;
        run_prog(100);
        check("t1_seq", seq, 64'h123413457);
        check("t1_agi_cycles", 64'(agi_cycles), 6);
        check("t1_agi_runs", 64'(agi_runs), 2);
        check("t1_spin_cycles", 64'(fast_cycles), 3);
        check("t1_rinses", 64'(rl_seq), 64'h10);
        check("t1_done_outs", 64'(outs), 64'b0000010);

        // DONE holds while start stays high
        repeat (3) @(negedge clk);
        check("t6_hold_done", 64'(st), 64'(DONE));
        start = 0;
        @(negedge clk);
        check("t6_idle", 64'(st), 64'(IDLE));
        check("t6_done_low", 64'(done), 0);

        // Three rinses, and the clamped second instance
        rinse_count = 2'd3;
        start = 1; start2 = 1;
        run_prog(200);
        check("t2_seq", seq, 64'h123413413413457);
        check("t2_agi_runs", 64'(agi_runs), 4);
        check("t2_agi_cycles", 64'(agi_cycles), 10);
        check("t2_rinses", 64'(rl_seq), 64'h3210);
        check("t2_clamp_runs", 64'(agi_runs2), 2);
        check("t2_clamp_rinses", 64'(rl_seq2), 64'h10);
        check("t2_clamp_state", 64'(st2), 64'(DONE));
        check("t2_clamp_outs", 64'(outs2), 64'b0000010);
        start = 0; start2 = 0;
        @(negedge clk);

        // Pause after two wash agitate cycles
        rinse_count = 2'd0;
        start = 1;
        wait_state(AGITATE, 20);
        @(negedge clk);
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_paused", 64'({st, motor_on, door_lock}), 64'({PAUSED, 1'b0, 1'b1}));
        end
        pause = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st == AGITATE) n++;
            else break;
        end
        check("t3_resume_cycles", 64'(n), 2);
        check("t3_drain", 64'(st), 64'(DRAIN));
        run_prog(50);
        check("t3_finish", 64'(st), 64'(DONE));
        start = 0;
        @(negedge clk);

        // Door opened during spin
        start = 1;
        wait_state(SPIN, 40);
        check("t4_in_spin", 64'(st), 64'(SPIN));
        door_closed = 0; drained = 0;
        @(negedge clk);
        check("t4_fault", 64'({st, outs}), 64'({FAULT, 7'b1000101}));
        drained = 1;
        @(negedge clk);
        check("t4_drained", 64'({st, outs}), 64'({FAULT, 7'b0000001}));
        door_closed = 1; start = 0;
        repeat (3) @(negedge clk);
        check("t4_sticky", 64'(st), 64'(FAULT));
        reset = 1;
        #1;
        check("t4_reset", 64'(st), 64'(IDLE));
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Fill watchdog, then asynchronous reset out of FAULT
        filled = 0; start = 1;
        wait_state(FILL, 20);
        n = (st == FILL) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st == FILL) n++;
            else break;
        end
        check("t5_fill_cycles", 64'(n), 8);
        check("t5_fault", 64'({st, fault}), 64'({FAULT, 1'b1}));
        start = 0;
        #1 reset = 1;
        #1;
        check("t5_async_outs", 64'({st, outs, rl}), 0);
        @(negedge clk);
        reset = 0; filled = 1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/washer_ctrl_gen2.md
Name: washer_ctrl_gen2

Overview:
Second-generation automatic washing-machine controller.
- Runs the full sequence: fill, detergent, wash agitate, drain, then N rinse cycles (fill, agitate, drain), spin, done.
- Timing uses internal parametrised down-counters instead of external timeout inputs.
- Adds pause/resume, a programmable rinse count, fill/drain watchdogs and a door-open fault state.
- Sits between the front-panel/sensor inputs and the valve/motor drivers.

Parameters:
TIMER_W, 16, width of all internal tick counters
WASH_TICKS, 1000, agitate duration of the wash phase, in clk cycles
RINSE_TICKS, 500, agitate duration of each rinse phase
SPIN_TICKS, 800, spin duration
FILL_TIMEOUT, 2000, max cycles in FILL before fault
DRAIN_TIMEOUT, 2000, max cycles in DRAIN before fault
MAX_RINSES, 3, clamp for rinse_count
RINSE_W, 2, width of rinse_count

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; begin program when in IDLE
pause  in  1  level; freeze AGITATE/SPIN
door_closed  in  1  door sensor
filled  in  1  water-level-high sensor
drained  in  1  water-level-empty sensor
detergent_added  in  1  detergent dispensed acknowledge
rinse_count  in  RINSE_W  rinse cycles requested, sampled at start
door_lock  out  1  door latch engaged
motor_on  out  1  drum motor enabled (agitate or spin)
motor_fast  out  1  spin speed select (valid with motor_on)
fill_valve_on  out  1  inlet valve
drain_valve_on  out  1  drain pump/valve
done  out  1  program complete
fault  out  1  fault latched
state_out  out  4  current state encoding, for debug
rinses_left  out  RINSE_W  remaining rinse cycles

Behaviour:
- Reset (async): state=IDLE, timers=0, rinses_left=0, wash_phase=1. All outputs 0.
- Outputs are a registered Moore decode. They change on the same clk edge as the state.
- Transitions take effect one clk after the sampled condition.
- IDLE, all outputs 0:
  - start=1 && door_closed=1 -> FILL.
  - Latch rinses_left = min(rinse_count, MAX_RINSES); set wash_phase=1.
- FILL: fill_valve_on=1, door_lock=1. Watchdog loaded with FILL_TIMEOUT on entry and decremented each cycle.
  - filled=1 -> DETERGENT if wash_phase, else AGITATE.
  - Watchdog reaching 0 with filled=0 -> FAULT.
- DETERGENT: door_lock=1. detergent_added=1 -> AGITATE.
- AGITATE: motor_on=1, door_lock=1. Timer loaded on entry with WASH_TICKS (wash_phase) or RINSE_TICKS; decrements when not paused.
  - Timer==0 -> DRAIN.
- DRAIN: drain_valve_on=1, door_lock=1. Watchdog loaded with DRAIN_TIMEOUT.
  - drained=1 and rinses_left>0: decrement rinses_left, clear wash_phase -> FILL.
  - drained=1 and rinses_left==0 -> SPIN.
  - Watchdog expiry -> FAULT.
- SPIN: motor_on=1, motor_fast=1, drain_valve_on=1, door_lock=1. Timer loaded with SPIN_TICKS.
  - Timer==0 -> DONE.
- PAUSED: entered from AGITATE/SPIN when pause=1.
  - motor off, valves off, door_lock=1, timer frozen.
  - Return state is saved. pause=0 -> return state, timer resumes without reload.
- DONE: done=1, door_lock=0. Held until start=0, then -> IDLE. No auto-restart on a held start.
- FAULT: fault=1, drain_valve_on=1 until drained=1, then 0. door_lock=1 until drained=1, then 0. Exit only by reset.
- Priority, highest first:
  1. reset
  2. door_closed=0 in any state other than IDLE/DONE/FAULT -> FAULT
  3. timer/watchdog expiry
  4. pause
  Pause and expiry in the same cycle: expiry wins and the transition proceeds.
- rinse_count=0 skips all rinses: DRAIN -> SPIN directly.
- Timers never underflow. A timer at 0 stays 0 and the counter saturates.
- Inputs are assumed already synchronised to clk.

Decomposition:
- Shared package washer_pkg holds:
  - state localparams: IDLE=0, FILL=1, DETERGENT=2, AGITATE=3, DRAIN=4, SPIN=5, PAUSED=6, DONE=7, FAULT=8 (4-bit);
  - the state width constant.
- One sub-module, washer_timer: loadable TIMER_W down-counter with load, load_value, enable, and an expired flag (count==0).
  - Instantiated twice: phase timer and watchdog.

Test Plan:
(Params for all scenarios: WASH_TICKS=4, RINSE_TICKS=2, SPIN_TICKS=3, FILL_TIMEOUT=8, DRAIN_TIMEOUT=8.)
1. Full run, rinse_count=1:
   - Stimulus: start=1 with door closed; assert filled, detergent_added, drained promptly.
   - Required: state sequence FILL, DETERGENT, AGITATE(4 cycles motor_on), DRAIN, FILL, AGITATE(2), DRAIN, SPIN(3 cycles motor_fast), DONE.
   - Required: done=1 and door_lock=0 in DONE.
2. rinse_count=3 with MAX_RINSES=3, then rinse_count=2 with MAX_RINSES=1:
   - Required: 3 rinse agitates in the first run, exactly 1 in the second.
   - Required: rinses_left counts down to 0.
3. Pause mid-wash:
   - Stimulus: pause=1 after 2 agitate cycles, hold 5 cycles, release.
   - Required: motor_on=0 and door_lock=1 while paused; exactly 2 further agitate cycles after release, then DRAIN.
4. Door opened during SPIN:
   - Required: FAULT next cycle, fault=1, motor_on=0, drain_valve_on=1.
   - Stimulus: assert drained. Required: door_lock=0. Only reset returns to IDLE.
5. filled never asserted:
   - Required: FAULT after 8 cycles in FILL.
   - Stimulus: reset mid-FAULT. Required: all outputs 0 asynchronously.
6. DONE with start still held:
   - Required: remain in DONE.
   - Stimulus: drop start. Required: IDLE next cycle, done=0.
